// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C sample packer slice.
// Holds the packer state encodings, the I2C byte width, the packed
// sample width and the packed-word typedef.
package i2c_pkg;

  // Packer states; encodings 2 and 3 are unused and recover to WAIT_MSB.
  localparam logic [1:0] WAIT_MSB = 2'd0;
  localparam logic [1:0] WAIT_LSB = 2'd1;

  localparam int I2C_BYTE_W = 8;
  localparam int PACKED_W   = 16;

  // Two bytes packed MSB-first: {msb, lsb}.
  typedef logic [PACKED_W-1:0] sample_t;

endpackage

// File: rtl/i2c_sample_fifo.sv
// First-word-fall-through FIFO for packed sensor samples.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   push, push_data   - write request and data (ignored when full unless popping)
//   pop               - consume head entry (ignored when empty)
//   head_data         - head entry, reads 0 while empty
//   full, empty       - occupancy flags
//   count             - entries stored, 0..DEPTH
module i2c_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; the head is masked to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/i2c_sample_packer.sv
// Pairs I2C read bytes MSB-first into sensor samples, buffers them in a
// FWFT FIFO and presents them over a valid/ready handshake.
// Optional build macro: I2C_PACKER_SIGN_EXT_EN - when defined, sample_data
// is 16 bits, sign-extended from bit DATA_W-1; otherwise DATA_W bits.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   frame_start                - realigns packing to the MSB byte
//   byte_valid, read_byte      - byte strobe and data from the I2C read FSM
//   sample_data, sample_valid  - head sample and non-empty flag
//   sample_ready               - consumer accepts head when valid is high
//   fifo_count                 - samples stored
//   overflow, overflow_clr     - sticky drop flag and its synchronous clear
//   state_info                 - packer state encoding for debug
module i2c_sample_packer
  import i2c_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     byte_valid,
  input  logic [I2C_BYTE_W-1:0]    read_byte,
`ifdef I2C_PACKER_SIGN_EXT_EN
  output logic [PACKED_W-1:0]      sample_data,
`else
  output logic [DATA_W-1:0]        sample_data,
`endif
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [1:0]               state_info
);

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic [I2C_BYTE_W-1:0] msb_reg;
  logic [I2C_BYTE_W-1:0] msb_next;
  logic                  overflow_reg;
  logic                  push;
  sample_t               word;
  logic [DATA_W-1:0]     push_data;
  logic [DATA_W-1:0]     head_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;

  assign word      = {msb_reg, read_byte};
  assign push_data = DATA_W'(word);

  always_comb begin
    state_next = state_reg;
    msb_next   = msb_reg;
    push       = 1'b0;
    if (frame_start) begin
      // Realign: a held MSB is discarded; a coincident byte becomes the new MSB.
      if (byte_valid) begin
        msb_next   = read_byte;
        state_next = WAIT_LSB;
      end else begin
        msb_next   = '0;
        state_next = WAIT_MSB;
      end
    end else begin
      case (state_reg)
        WAIT_MSB: begin
          if (byte_valid) begin
            msb_next   = read_byte;
            state_next = WAIT_LSB;
          end
        end
        WAIT_LSB: begin
          if (byte_valid) begin
            push       = 1'b1;
            state_next = WAIT_MSB;
          end
        end
        default: state_next = WAIT_MSB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= WAIT_MSB;
      msb_reg   <= '0;
    end else begin
      state_reg <= state_next;
      msb_reg   <= msb_next;
    end
  end

  assign pop  = sample_ready && !fifo_empty;
  // A sample is lost only when full and nothing leaves in the same cycle.
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (overflow_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  i2c_sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef I2C_PACKER_SIGN_EXT_EN
  assign sample_data = PACKED_W'($signed(head_data));
`else
  assign sample_data = head_data;
`endif

  assign sample_valid = !fifo_empty;
  assign overflow     = overflow_reg;
  assign state_info   = state_reg;

endmodule

// File: tb/tb_i2c_sample_packer.sv
module tb_i2c_sample_packer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 12;
`ifdef I2C_PACKER_SIGN_EXT_EN
  localparam int OUT_W = 16;
`else
  localparam int OUT_W = DATA_W;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             frame_start = 1'b0;
  logic             byte_valid = 1'b0;
  logic [7:0]       read_byte = 8'h00;
  logic [OUT_W-1:0] sample_data;
  logic             sample_valid;
  logic             sample_ready = 1'b0;
  logic [3:0]       fifo_count;
  logic             overflow;
  logic             overflow_clr = 1'b0;
  logic [1:0]       state_info;

  int checks = 0;
  int errors = 0;

  // Scoreboard and packing model
  logic [OUT_W-1:0] exp_q[$];
  bit               have_msb = 0;
  logic [7:0]       m_msb = 8'h00;

  i2c_sample_packer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .byte_valid   (byte_valid),
    .read_byte    (read_byte),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .state_info   (state_info)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] exp_out(input logic [DATA_W-1:0] v);
`ifdef I2C_PACKER_SIGN_EXT_EN
    return {{(OUT_W-DATA_W){v[DATA_W-1]}}, v};
`else
    return v;
`endif
  endfunction

  // Called at a negedge; drives one byte strobe across the next posedge and
  // returns at the following negedge. rdy also pops the head at that edge.
  task automatic send_byte(input logic [7:0] b, input bit fs, input bit rdy);
    logic [15:0]      w;
    logic [OUT_W-1:0] h;
    read_byte    = b;
    byte_valid   = 1'b1;
    frame_start  = fs;
    sample_ready = rdy;
    if (rdy && sample_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_in_send: got %h, expected nothing queued", sample_data);
      end else begin
        h = exp_q.pop_front();
        if (sample_data !== h) begin
          errors++;
          $display("FAIL pop_in_send: sample_data=%h expected %h", sample_data, h);
        end
      end
    end
    if (fs || !have_msb) begin
      have_msb = 1;
      m_msb    = b;
    end else begin
      have_msb = 0;
      w = {m_msb, b};
      if (exp_q.size() < DEPTH) exp_q.push_back(exp_out(w[DATA_W-1:0]));
    end
    @(negedge clk);
    byte_valid   = 1'b0;
    frame_start  = 1'b0;
    sample_ready = 1'b0;
    $display("byte %h fs=%0d rdy=%0d -> count=%0d valid=%0d state=%0d",
             b, fs, rdy, fifo_count, sample_valid, state_info);
  endtask

  task automatic push_sample(input logic [15:0] v, input bit rdy);
    logic [15:0] t;
    t = v;
    send_byte(t[15:8], 1'b0, 1'b0);
    send_byte(t[7:0], 1'b0, rdy);
  endtask

  task automatic drain(input string name, input int n_exp);
    int n;
    logic [OUT_W-1:0] h;
    n = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (sample_valid !== 1'b1) break;
      sample_ready = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_extra: got %h, expected nothing", name, sample_data);
      end else begin
        h = exp_q.pop_front();
        if (sample_data !== h) begin
          errors++;
          $display("FAIL %s_data: sample_data=%h expected %h", name, sample_data, h);
        end else begin
          $display("pop %s sample %h", name, sample_data);
        end
      end
      n++;
      @(negedge clk);
    end
    sample_ready = 1'b0;
    checks++;
    if (n != n_exp) begin
      errors++;
      $display("FAIL %s_drain_count: got %0d expected %0d", name, n, n_exp);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d expected samples never appeared", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check1("reset_valid", 16'(sample_valid), 16'h0);
    check1("reset_data", 16'(sample_data), 16'h0);
    check1("reset_count", 16'(fifo_count), 16'h0);
    check1("reset_overflow", 16'(overflow), 16'h0);
    check1("reset_state", 16'(state_info), 16'h0);
    reset = 1'b0;
    @(negedge clk);
    have_msb = 0;
    $display("reset released");
  endtask

  task automatic test_basic();
    send_byte(8'hAB, 1'b0, 1'b0);
    check1("basic_valid_before", 16'(sample_valid), 16'h0);
    send_byte(8'hCD, 1'b0, 1'b0);
    check1("basic_valid", 16'(sample_valid), 16'h1);
    check1("basic_data", 16'(sample_data), 16'(exp_out(12'hBCD)));
    check1("basic_count", 16'(fifo_count), 16'h1);
    drain("basic", 1);
  endtask

  task automatic test_frame_start();
    send_byte(8'h12, 1'b0, 1'b0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    have_msb = 0;
    check1("fs_state", 16'(state_info), 16'h0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h56, 1'b0, 1'b0);
    check1("fs_count", 16'(fifo_count), 16'h1);
    check1("fs_data", 16'(sample_data), 16'(exp_out(12'h456)));
    drain("fs", 1);
  endtask

  task automatic test_coincident();
    send_byte(8'h7F, 1'b1, 1'b0);
    check1("coinc_state", 16'(state_info), 16'h1);
    send_byte(8'h80, 1'b0, 1'b0);
    check1("coinc_data", 16'(sample_data), 16'(exp_out(12'hF80)));
    drain("coinc", 1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) push_sample(16'h1000 + 16'(i * 16'h0111), 1'b0);
    check1("ovf_count", 16'(fifo_count), 16'(DEPTH));
    check1("ovf_flag", 16'(overflow), 16'h1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check1("ovf_clear", 16'(overflow), 16'h0);
    drain("ovf", DEPTH);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) push_sample(16'h2A00 + 16'(i * 16'h0013), 1'b0);
    check1("b2b_full", 16'(fifo_count), 16'(DEPTH));
    push_sample(16'h3C5A, 1'b1);
    check1("b2b_count", 16'(fifo_count), 16'(DEPTH));
    check1("b2b_overflow", 16'(overflow), 16'h0);
    drain("b2b", DEPTH);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_sample(16'h0700 + 16'(i), 1'b0);
    send_byte(8'h99, 1'b0, 1'b0);
    check1("mid_pre_state", 16'(state_info), 16'h1);
    check1("mid_pre_count", 16'(fifo_count), 16'h3);
    #2;
    reset = 1'b1;
    #1;
    check1("mid_count", 16'(fifo_count), 16'h0);
    check1("mid_valid", 16'(sample_valid), 16'h0);
    check1("mid_state", 16'(state_info), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    have_msb = 0;
    @(negedge clk);
    $display("reset mid-sample done");
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    check1("mid_after", 16'(sample_data), 16'(exp_out(12'h233)));
    drain("mid", 1);
  endtask

  task automatic test_sign_ext();
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
`ifdef I2C_PACKER_SIGN_EXT_EN
    check1("sext_data", 16'(sample_data), 16'hF800);
`else
    check1("sext_data", 16'(sample_data), 16'h0800);
`endif
    drain("sext", 1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_frame_start();
    test_coincident();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_sign_ext();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/i2c_sample_packer.md
Name: i2c_sample_packer

Overview:
Downstream stage of the I2C read FSM. It consumes the byte strobe and byte bus produced by the I2C read FSM and pairs bytes MSB-first into sensor samples. It buffers those samples in a small first-word-fall-through FIFO and presents them to the synth voice/control logic over a valid/ready handshake. It decouples I2C bus timing from the audio-side consumer.

Parameters:
DEPTH, 8, FIFO depth in samples; power of 2, at least 2.
DATA_W, 12, output sample width; the low DATA_W bits of the packed 16-bit word {msb,lsb}; 1..16.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
frame_start  input  1  one-cycle pulse at start of each I2C read transaction; realigns packing to MSB
byte_valid  input  1  one-cycle strobe; read_byte is valid this cycle
read_byte  input  8  byte received by the I2C read FSM
sample_data  output  DATA_W  head-of-FIFO sample
sample_valid  output  1  FIFO non-empty
sample_ready  input  1  consumer accepts the head sample when high together with sample_valid
fifo_count  output  $clog2(DEPTH)+1  number of samples stored
overflow  output  1  sticky; a completed sample was dropped because the FIFO was full
overflow_clr  input  1  synchronous clear of overflow
state_info  output  2  debug: packer state encoding

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on port reset. All state is cleared immediately on reset assertion.
- Reset values: sample_valid=0, sample_data=0, fifo_count=0, overflow=0, state_info=WAIT_MSB (2'd0), held MSB=0, FIFO pointers=0.
- State machine has two states: WAIT_MSB (0) and WAIT_LSB (1). Encodings 2 and 3 are unused; if ever reached, the next clock returns to WAIT_MSB.
- WAIT_MSB with byte_valid: latch read_byte as msb, go to WAIT_LSB.
- WAIT_LSB with byte_valid: form word={msb,read_byte}, push word[DATA_W-1:0], go to WAIT_MSB.
- frame_start has priority over the current state: the state is forced to WAIT_MSB and any held msb is discarded. If frame_start and byte_valid occur in the same cycle, the byte is taken as the new MSB and the state goes to WAIT_LSB.
- Push latency: a push on the LSB byte_valid at edge N gives sample_valid=1 and sample_data=that sample after edge N when the FIFO was empty, i.e. visible in cycle N+1.
- Pop: occurs at the clock edge when sample_valid && sample_ready. sample_data is first-word-fall-through and shows the next entry in the following cycle.
- Push and pop in the same cycle: both take effect and fifo_count is unchanged. When the FIFO is full, a same-cycle pop frees the slot, so the push is accepted.
- Push when full with no pop: the sample is dropped, FIFO contents are unchanged, and overflow is set at the next edge.
- overflow_clr: clears overflow at the next edge. If an overflow event occurs in the same cycle as overflow_clr, the set wins.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count saturates at DEPTH and never exceeds it.
- sample_ready while empty: no effect.
- byte_valid is held for multiple cycles: each cycle counts as a separate byte. Upstream guarantees single-cycle strobes.
- Reset during WAIT_LSB: the half-formed sample is lost and no push occurs.

Optional Feature:
Macro I2C_PACKER_SIGN_EXT_EN.
- Defined: sample_data is treated as signed. The packed word's bit DATA_W-1 is replicated, so the output port widens to 16 bits, sign-extended (two's-complement sensor data).
- Undefined: sample_data is DATA_W bits, zero-truncated as described above.
- FIFO storage width stays DATA_W in both builds; sign extension happens on the output only.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings (WAIT_MSB=2'd0, WAIT_LSB=2'd1)
  - constant I2C_BYTE_W=8
  - constant PACKED_W=16
  - the sample_t typedef for the packed word.
- One sub-module, i2c_sample_fifo: parameterised DEPTH/width, first-word-fall-through, async active-high reset, push/pop/full/empty/count. Overflow logic stays in the packer.

Test Plan:
- Reset, then bytes 0xAB then 0xCD with DATA_W=12 -> sample_valid=1 one cycle after the 0xCD strobe; sample_data=0xBCD; fifo_count=1.
- Byte 0x12, then frame_start, then bytes 0x34, 0x56 -> exactly one sample, 0x456; 0x12 is discarded.
- frame_start coincident with byte 0x7F, then byte 0x80 -> sample 0xF80; state_info reads 1 in the cycle after the coincident strobe.
- sample_ready=0, push 9 samples with DEPTH=8 -> fifo_count=8, overflow=1, and the 9th sample is absent on drain. Pulse overflow_clr -> overflow=0.
- FIFO full, sample_ready=1 while a 9th sample completes -> push accepted, fifo_count stays 8, no overflow, drain order is preserved.
- Reset asserted mid-sample (state WAIT_LSB, FIFO holds 3) -> immediately fifo_count=0, sample_valid=0, state_info=0. With I2C_PACKER_SIGN_EXT_EN defined, bytes 0x08, 0x00 -> sample_data=16'hF800.
